memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 89 ++++++++
 tb/tb_memory_access.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// MEM stage: data memory, branch resolve and MEM/WB pipeline register. Optional MEM_MISALIGN_CHECK_EN adds a sticky misalignment flag.
// Latency: pc_branch/PCSrc combinational; read data and forwarded fields 1 cycle.
// Backpressure: none, one instruction accepted every cycle unconditionally.
module memory_access #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] add_result_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] r_data2_in,
    input  logic [4:0]  mux_RegDst_in,
    input  logic        zero_in,
    input  logic        wb_RegWrite_in,
    input  logic        wb_MemtoReg_in,
    input  logic        m_Branch_in,
    input  logic        m_MemRead_in,
    input  logic        m_MemWrite_in,
    output logic [31:0] pc_branch,
    output logic        PCSrc,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  mux_RegDst_out,
    output logic        wb_RegWrite_out,
    output logic        wb_MemtoReg_out,
    output logic        misaligned_out
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic          access_ok;
    logic          mem_we;

    assign pc_branch = add_result_in;
    assign PCSrc     = m_Branch_in & zero_in;

    // Bits above the word index are dropped, so addresses wrap modulo 4*DEPTH bytes.
    assign word_idx = alu_result_in[AW+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
    logic misaligned;
    logic misaligned_q;

    assign misaligned = (m_MemRead_in | m_MemWrite_in) && (alu_result_in[1:0] != 2'b00);
    assign access_ok  = ~misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (misaligned) begin
            misaligned_q <= 1'b1;
        end
    end

    assign misaligned_out = misaligned_q;
`else
    assign access_ok      = 1'b1;
    assign misaligned_out = 1'b0;
`endif

    // Reset gates the write but never clears the array contents.
    assign mem_we = m_MemWrite_in & access_ok & ~reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= r_data2_in;
        end
    end

    // The read samples mem before the same-edge write lands: read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_out   <= '0;
            alu_result_out  <= '0;
            mux_RegDst_out  <= '0;
            wb_RegWrite_out <= 1'b0;
            wb_MemtoReg_out <= 1'b0;
        end else begin
            read_data_out   <= (m_MemRead_in && access_ok) ? mem[word_idx] : '0;
            alu_result_out  <= alu_result_in;
            mux_RegDst_out  <= mux_RegDst_in;
            wb_RegWrite_out <= wb_RegWrite_in;
            wb_MemtoReg_out <= wb_MemtoReg_in;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access against an array-based reference model.
module tb_memory_access;

    localparam int DEPTH = 128;
`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] add_result_in = '0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] r_data2_in = '0;
    logic [4:0]  mux_RegDst_in = '0;
    logic        zero_in = 1'b0;
    logic        wb_RegWrite_in = 1'b0;
    logic        wb_MemtoReg_in = 1'b0;
    logic        m_Branch_in = 1'b0;
    logic        m_MemRead_in = 1'b0;
    logic        m_MemWrite_in = 1'b0;
    logic [31:0] pc_branch;
    logic        PCSrc;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  mux_RegDst_out;
    logic        wb_RegWrite_out;
    logic        wb_MemtoReg_out;
    logic        misaligned_out;

    logic [31:0] mem_m [DEPTH];
    logic        mis_m = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    memory_access #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .add_result_in(add_result_in), .alu_result_in(alu_result_in), .r_data2_in(r_data2_in),
        .mux_RegDst_in(mux_RegDst_in), .zero_in(zero_in),
        .wb_RegWrite_in(wb_RegWrite_in), .wb_MemtoReg_in(wb_MemtoReg_in),
        .m_Branch_in(m_Branch_in), .m_MemRead_in(m_MemRead_in), .m_MemWrite_in(m_MemWrite_in),
        .pc_branch(pc_branch), .PCSrc(PCSrc),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .mux_RegDst_out(mux_RegDst_out), .wb_RegWrite_out(wb_RegWrite_out),
        .wb_MemtoReg_out(wb_MemtoReg_out), .misaligned_out(misaligned_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"},  read_data_out, 32'h0);
        chk({tag, "_alu"}, alu_result_out, 32'h0);
        chk({tag, "_dst"}, 32'(mux_RegDst_out), 32'h0);
        chk({tag, "_rw"},  32'(wb_RegWrite_out), 32'h0);
        chk({tag, "_m2r"}, 32'(wb_MemtoReg_out), 32'h0);
        chk({tag, "_mis"}, 32'(misaligned_out), 32'h0);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic br, input logic z, input logic [31:0] tgt,
                       input logic [4:0] dst, input logic rw, input logic m2r);
        logic        mis;
        int          idx;
        logic [31:0] exp_rd;
        m_MemRead_in   = rd;
        m_MemWrite_in  = wr;
        alu_result_in  = addr;
        r_data2_in     = data;
        m_Branch_in    = br;
        zero_in        = z;
        add_result_in  = tgt;
        mux_RegDst_in  = dst;
        wb_RegWrite_in = rw;
        wb_MemtoReg_in = m2r;
        #1;
        chk("pc_branch", pc_branch, tgt);
        chk("PCSrc", 32'(PCSrc), 32'(br & z));
        mis    = CHK_EN && (rd || wr) && (addr % 4 != 0);
        idx    = int'((addr / 4) % DEPTH);
        exp_rd = (rd && !mis) ? mem_m[idx] : 32'h0;
        if (wr && !mis) mem_m[idx] = data;
        if (mis) mis_m = 1'b1;
        @(posedge clk);
        #1;
        chk("read_data", read_data_out, exp_rd);
        chk("alu_result", alu_result_out, addr);
        chk("RegDst", 32'(mux_RegDst_out), 32'(dst));
        chk("RegWrite", 32'(wb_RegWrite_out), 32'(rw));
        chk("MemtoReg", 32'(wb_MemtoReg_out), 32'(m2r));
        chk("misaligned", 32'(misaligned_out), 32'(mis_m));
        @(negedge clk);
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
        cyc(1'b0, 1'b1, addr, data, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic rd_word(input logic [31:0] addr);
        cyc(1'b1, 1'b0, addr, 32'h0, 1'b0, 1'b0, 32'h0, 5'd3, 1'b1, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] before13;
        #1;
        chk_all_zero("reset_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Fill the whole array so every later read has a defined model value.
        for (int i = 0; i < DEPTH; i++) wr_word(32'(i * 4), $urandom);

        wr_word(32'h10, 32'hDEADBEEF);
        rd_word(32'h10);
        chk("store_load", read_data_out, 32'hDEADBEEF);

        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 5'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 5'd0, 1'b0, 1'b0);

        wr_word(32'h8, 32'h1);
        cyc(1'b1, 1'b1, 32'h8, 32'h2, 1'b0, 1'b0, 32'h0, 5'd7, 1'b1, 1'b1);
        chk("rbw_old", read_data_out, 32'h1);
        rd_word(32'h8);
        chk("rbw_new", read_data_out, 32'h2);

        wr_word(32'h200, 32'h55);
        rd_word(32'h0);
        chk("wrap", read_data_out, 32'h55);

        wr_word(32'h10, 32'h11111111);
        before13 = mem_m[4];
        wr_word(32'h13, 32'h77);
        rd_word(32'h10);
        chk("store_0x13", read_data_out, CHK_EN ? before13 : 32'h77);
        chk("mis_sticky", 32'(misaligned_out), 32'(CHK_EN));

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            cyc(1'($urandom), 1'($urandom), a, $urandom, 1'($urandom), 1'($urandom),
                $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset mid-cycle with nonzero registered outputs, then a write that must be dropped.
        wr_word(32'h20, 32'h12345678);
        rd_word(32'h20);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("reset_async");
        m_MemRead_in  = 1'b0;
        m_MemWrite_in = 1'b1;
        alu_result_in = 32'h20;
        r_data2_in    = 32'hAAAA5555;
        @(posedge clk);
        #1;
        chk_all_zero("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        mis_m = 1'b0;
        rd_word(32'h20);
        chk("reset_no_write", read_data_out, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
